// File: rtl/fp25519_pkg.sv
// Shared definitions for the GF(2^255-19) digit-serial multiplier.
// Holds the field prime, the fold constant, the controller state encoding
// and helpers for the final conditional subtraction and DIGIT_W legality.
package fp25519_pkg;

    localparam int unsigned FE_W   = 256;
    localparam int unsigned FOLD_C = 19;

    // p = 2^255 - 19
    localparam logic [FE_W-1:0] P_25519 = {1'b0, {247{1'b1}}, 8'hED};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIN,
        DONE
    } state_e;

    // One conditional subtraction; callers guarantee x < 2p.
    function automatic logic [FE_W-1:0] sub_p(input logic [FE_W-1:0] x);
        return (x >= P_25519) ? (x - P_25519) : x;
    endfunction

    function automatic logic digit_w_legal(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16);
    endfunction

endpackage

// File: rtl/fp25519_fold.sv
// Combinational pseudo-Mersenne fold: y = x[254:0] + 19 * (x >> 255).
// Ports:
//   x_i   : IN_W-bit value to reduce (IN_W >= 256)
//   y_c_o : 256-bit folded value, congruent to x_i mod p
module fp25519_fold
    import fp25519_pkg::*;
#(
    parameter int unsigned IN_W = 256
) (
    input  logic [IN_W-1:0] x_i,
    output logic [FE_W-1:0] y_c_o
);

    localparam int unsigned HI_W = IN_W - 255;

    logic [HI_W-1:0] hi;

    // 2^255 == 19 (mod p), so the bits above 254 re-enter scaled by 19.
    assign hi    = x_i[IN_W-1:255];
    assign y_c_o = FE_W'(x_i[254:0]) + FE_W'(hi) * FE_W'(FOLD_C);

endmodule

// File: rtl/fp25519_mul_ds.sv
// Digit-serial modular multiplier over GF(2^255-19), MSB-first over B.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_in_valid / o_in_ready   : operand handshake (ready only in IDLE)
//   i_mode                    : 0 = A*B, 1 = A*A (i_b ignored)
//   i_a, i_b                  : 256-bit operands, any value
//   o_out_valid / i_out_ready : result handshake
//   o_result                  : canonical product in [0, p-1]
module fp25519_mul_ds
    import fp25519_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic            i_mode,
    input  logic [FE_W-1:0] i_a,
    input  logic [FE_W-1:0] i_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [FE_W-1:0] o_result
);

    localparam int unsigned N     = FE_W / DIGIT_W;
    localparam int unsigned CNT_W = $clog2(N) + 1;
    localparam int unsigned ACC_W = 257 + DIGIT_W;

    if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
        $error("fp25519_mul_ds: DIGIT_W must be 1, 2, 4, 8 or 16");
    end

    state_e            state_q, state_d;
    logic [FE_W-1:0]   a_q, a_d;
    logic [FE_W-1:0]   b_q, b_d;
    logic [FE_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FE_W-1:0]   result_q, result_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DIGIT_W-1:0] digit;
    logic [ACC_W-1:0]   acc_sum;
    logic [FE_W-1:0]    fold_a_in;
    logic [FE_W-1:0]    fold_a;
    logic [FE_W-1:0]    fold_b;
    logic [FE_W-1:0]    fold_it;

    // B is shifted left each iteration, so the current digit is always on top.
    assign digit   = b_q[FE_W-1 -: DIGIT_W];
    assign acc_sum = (ACC_W'(acc_q) << DIGIT_W) + ACC_W'(a_q) * ACC_W'(digit);

    // Shared 256-bit fold: canonicalises A in PREP, reduces acc in FIN.
    assign fold_a_in = (state_q == FIN) ? acc_q : a_q;

    fp25519_fold #(.IN_W(FE_W)) u_fold_a (
        .x_i   (fold_a_in),
        .y_c_o (fold_a)
    );

    fp25519_fold #(.IN_W(FE_W)) u_fold_b (
        .x_i   (b_q),
        .y_c_o (fold_b)
    );

    fp25519_fold #(.IN_W(ACC_W)) u_fold_it (
        .x_i   (acc_sum),
        .y_c_o (fold_it)
    );

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (i_in_valid && in_ready_q) begin
                    a_d     = i_a;
                    b_d     = i_mode ? i_a : i_b;
                    acc_d   = '0;
                    state_d = PREP;
                end
            end
            PREP: begin
                a_d     = sub_p(fold_a);
                b_d     = sub_p(fold_b);
                cnt_d   = CNT_W'(N - 1);
                state_d = ITER;
            end
            ITER: begin
                // A < p and acc < 2^256 keep the fold output below 2^256.
                acc_d = fold_it;
                b_d   = b_q << DIGIT_W;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // acc < 2^256 folds to below p + 38, so one subtraction suffices.
                result_d = sub_p(fold_a);
                state_d  = DONE;
            end
            DONE: begin
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_fp25519_mul_ds.sv
// Self-checking bench for fp25519_mul_ds: three instances (DIGIT_W 1, 4, 16)
// share operand buses; results are compared with a wide-integer modular model.
module tb_fp25519_mul_ds;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [255:0] a, b;
    logic         in_valid  [NI];
    logic         out_ready [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic [255:0] result    [NI];

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] P;
    logic [255:0] ones;

    always #5 clk = ~clk;

    function automatic int dw_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fp25519_mul_ds #(.DIGIT_W(dw_of(g))) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_in_valid  (in_valid[g]),
            .o_in_ready  (in_ready[g]),
            .i_mode      (mode),
            .i_a         (a),
            .i_b         (b),
            .o_out_valid (out_valid[g]),
            .i_out_ready (out_ready[g]),
            .o_result    (result[g])
        );
    end

    // Reference: exact product of the raw operands, reduced mod p.
    function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y,
                                             input logic m);
        logic [511:0] pr;
        logic [511:0] pw;
        pr = 512'(x) * (m ? 512'(x) : 512'(y));
        pw = 512'(P);
        return 256'(pr % pw);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        int unsigned  sel;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        sel = $urandom_range(0, 7);
        if (sel == 0) r = P + 256'($urandom_range(0, 40));
        else if (sel == 1) r = ones - 256'($urandom_range(0, 40));
        else if (sel == 2) r = 256'($urandom);
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input int k, input logic [255:0] av, input logic [255:0] bv,
                            input logic mv);
        int w;
        w = 0;
        while (!in_ready[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 256'(in_ready[k]), 256'(1));
        a = av;
        b = bv;
        mode = mv;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        // Operands are only sampled at the accept edge.
        a = ~av;
        b = ~bv;
        mode = ~mv;
    endtask

    // cyc counts cycles with the accept edge closing cycle 0.
    task automatic wait_result(input int k, output int cyc);
        cyc = 1;
        while (!out_valid[k] && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input int k, input logic [255:0] av, input logic [255:0] bv,
                         input logic mv, input logic [255:0] exp, input string tag);
        int cyc;
        start_op(k, av, bv, mv);
        wait_result(k, cyc);
        check({tag, "_lat"}, 256'(cyc), 256'(256 / dw_of(k) + 3));
        check(tag, result[k], exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vdrop"}, 256'(out_valid[k]), 256'(0));
        check({tag, "_rdy"}, 256'(in_ready[k]), 256'(1));
        check({tag, "_hold"}, result[k], exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] ra, rb, e;
        logic         rm;
        int           cyc;
        int           nrand;

        P    = (256'd1 << 255) - 256'd19;
        ones = '1;
        rst  = 1'b1;
        mode = 1'b0;
        a    = '0;
        b    = '0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready[1]), 256'(0));
        check("rst_out_valid", 256'(out_valid[1]), 256'(0));
        check("rst_result", result[1], 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 256'(in_ready[1]), 256'(1));

        // Directed cases on the DIGIT_W=4 instance
        do_op(1, ones, 256'd1, 1'b0, 256'd37, "noncanon_a");
        do_op(1, P, 256'd5, 1'b0, 256'd0, "a_eq_p");
        do_op(1, P - 256'd1, P - 256'd1, 1'b0, 256'd1, "pm1_sq");
        do_op(1, P - 256'd1, rand256(), 1'b1, 256'd1, "mode_sq");
        do_op(1, 256'd2, 256'd1 << 254, 1'b0, 256'd19, "pow2_wrap");
        do_op(1, 256'd0, ones, 1'b0, 256'd0, "zero_a");

        // Backpressure: result held, no new accept until handshake
        out_ready[1] = 1'b0;
        ra = 256'd123456789;
        rb = P + 256'd4;
        e  = ref_mul(ra, rb, 1'b0);
        start_op(1, ra, rb, 1'b0);
        wait_result(1, cyc);
        check("bp_lat", 256'(cyc), 256'(67));
        check("bp_result", result[1], e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", result[1], e);
            check("bp_in_ready", 256'(in_ready[1]), 256'(0));
            check("bp_valid", 256'(out_valid[1]), 256'(1));
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rdy_after", 256'(in_ready[1]), 256'(1));
        check("bp_vdrop", 256'(out_valid[1]), 256'(0));
        check("bp_keep", result[1], e);

        // Reset in the middle of an operation
        start_op(1, 256'd11, 256'd13, 1'b0);
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 256'(out_valid[1]), 256'(0));
        check("midrst_result", result[1], 256'(0));
        check("midrst_in_ready", 256'(in_ready[1]), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        do_op(1, 256'd3, 256'd7, 1'b0, 256'd21, "after_rst");

        // Random regression on every digit width
        for (int k = 0; k < NI; k++) begin
            nrand = (k == 0) ? 60 : ((k == 1) ? 300 : 600);
            for (int i = 0; i < nrand; i++) begin
                ra = rand256();
                rb = rand256();
                rm = ($urandom_range(0, 4) == 0);
                do_op(k, ra, rb, rm, ref_mul(ra, rb, rm), $sformatf("rand_dw%0d", dw_of(k)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
